shd_frame_ctrl: RTL

SHD_FRAME_CTRL -- requirements
Module: shd_frame_ctrl

---
 rtl/shd_pkg.sv | 38 +++
 rtl/shd_xy_counter.sv | 62 ++++++
 rtl/shd_frame_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/shd_pkg.sv
// Shared types and constant helpers for the shading-window frame controller.
package shd_pkg;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } shd_state_e;

  // Default geometry: 13x13 window over a 650x480 image.
  localparam int unsigned SHD_WH_DEF = 32'd13;
  localparam int unsigned SHD_M_DEF  = 32'd650;
  localparam int unsigned SHD_N_DEF  = 32'd480;

  // Aggregator pipeline latency in flush cycles for a WH x WH window on an M-wide image.
  function automatic int unsigned shd_lat(input int unsigned wh, input int unsigned m);
    return ((wh - 32'd1) * m + (wh - 32'd1)) / 32'd2 + 32'd4;
  endfunction

  // Width of the pixel counters: must hold the value M*N itself.
  function automatic int unsigned shd_cnt_w(input int unsigned m, input int unsigned n);
    return $clog2(m * n + 32'd1);
  endfunction

  // Width of the column coordinate.
  function automatic int unsigned shd_x_w(input int unsigned m);
    return (m > 32'd1) ? $clog2(m) : 32'd1;
  endfunction

  // Width of the row coordinate.
  function automatic int unsigned shd_y_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/shd_xy_counter.sv
// Raster-order x/y coordinate counter: x wraps at M-1, y saturates at N-1.
module shd_xy_counter
  import shd_pkg::*;
#(
  parameter int unsigned M   = SHD_M_DEF,
  parameter int unsigned N   = SHD_N_DEF,
  parameter int unsigned X_W = shd_x_w(M),
  parameter int unsigned Y_W = shd_y_w(N)
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_clr,
  input  logic           i_inc,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y
);

  localparam logic [X_W-1:0] X_LAST = X_W'(M - 32'd1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(N - 32'd1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  // Next coordinate: clear wins over increment; row stops at the last line.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_clr) begin
      x_d = {X_W{1'b0}};
      y_d = {Y_W{1'b0}};
    end else if (i_inc) begin
      if (x_q == X_LAST) begin
        x_d = {X_W{1'b0}};
        if (y_q != Y_LAST) begin
          y_d = y_q + 1'b1;
        end else begin
          y_d = y_q;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Coordinate registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      x_q <= {X_W{1'b0}};
      y_q <= {Y_W{1'b0}};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign o_x = x_q;
  assign o_y = y_q;

endmodule

// File: rtl/shd_frame_ctrl.sv
// Frame controller for the window aggregator: clears it, streams M*N pixels,
// flushes the pipeline with zeros and tags each window result with x/y.
module shd_frame_ctrl
  import shd_pkg::*;
#(
  parameter int unsigned WH = SHD_WH_DEF,
  parameter int unsigned M  = SHD_M_DEF,
  parameter int unsigned N  = SHD_N_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  input  logic                   i_pix_val,
  output logic                   o_pix_rdy,
  output logic                   o_win_dval,
  output logic                   o_data_sel,
  output logic                   o_win_rstn,
  input  logic                   i_win_dval,
  output logic                   o_out_val,
  output logic [shd_x_w(M)-1:0]  o_out_x,
  output logic [shd_y_w(N)-1:0]  o_out_y,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned CNT_W = shd_cnt_w(M, N);
  localparam int unsigned X_W   = shd_x_w(M);
  localparam int unsigned Y_W   = shd_y_w(N);
  localparam int unsigned LAT   = shd_lat(WH, M);
  // Flush normally ends after LAT cycles; twice that means the aggregator is stuck.
  localparam int unsigned WD_LIM = 32'd2 * LAT;
  localparam int unsigned WD_W   = $clog2(WD_LIM + 32'd1);

  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(M * N);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(M * N - 32'd1);
  localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(WD_LIM);

  shd_state_e       state_q, state_d;
  logic             clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             pix_rdy_q, pix_rdy_d;
  logic             data_sel_q, data_sel_d;
  logic             win_rstn_q, win_rstn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pix_acc_s;
  logic             out_hit_s;
  logic             cnt_clr_s;

  // Next-state, counter and registered-output decode; outputs follow state_d so they line up with the state.
  always_comb begin
    pix_acc_s = i_pix_val & pix_rdy_q;
    out_hit_s = i_win_dval & busy_q & (out_cnt_q < PIX_TOTAL);
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    in_cnt_d  = in_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    if (out_hit_s) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end else begin
      out_cnt_d = out_cnt_q;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d   = ST_CLR;
          clr_cnt_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_CLR: begin
        if (clr_cnt_q) begin
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (pix_acc_s) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == PIX_LAST) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          in_cnt_d = in_cnt_q;
        end
      end
      ST_FLUSH: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if ((out_cnt_d == PIX_TOTAL) || (wd_cnt_q == WD_MAX)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every frame starts and ends with zeroed counters.
    cnt_clr_s = (state_d == ST_CLR) || (state_d == ST_DONE);
    if (cnt_clr_s) begin
      in_cnt_d  = {CNT_W{1'b0}};
      out_cnt_d = {CNT_W{1'b0}};
      wd_cnt_d  = {WD_W{1'b0}};
    end else begin
      in_cnt_d  = in_cnt_d;
      out_cnt_d = out_cnt_d;
      wd_cnt_d  = wd_cnt_d;
    end
    pix_rdy_d  = (state_d == ST_RUN);
    data_sel_d = (state_d == ST_FLUSH);
    win_rstn_d = (state_d != ST_CLR);
    busy_d     = (state_d == ST_CLR) || (state_d == ST_RUN) || (state_d == ST_FLUSH);
    done_d     = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // State, counters and registered outputs; reset holds the aggregator cleared.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      clr_cnt_q  <= 1'b0;
      in_cnt_q   <= {CNT_W{1'b0}};
      out_cnt_q  <= {CNT_W{1'b0}};
      wd_cnt_q   <= {WD_W{1'b0}};
      pix_rdy_q  <= 1'b0;
      data_sel_q <= 1'b0;
      win_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      pix_rdy_q  <= pix_rdy_d;
      data_sel_q <= data_sel_d;
      win_rstn_q <= win_rstn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  shd_xy_counter #(
    .M   (M),
    .N   (N),
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_out_xy (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (cnt_clr_s),
    .i_inc  (out_hit_s),
    .o_x    (o_out_x),
    .o_y    (o_out_y)
  );

  // Valid to the aggregator: accepted pixels in RUN, a zero every cycle in FLUSH.
  assign o_win_dval = pix_acc_s | data_sel_q;
  assign o_out_val  = out_hit_s;
  assign o_pix_rdy  = pix_rdy_q;
  assign o_data_sel = data_sel_q;
  assign o_win_rstn = win_rstn_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule
